// File: rtl/rca_mw_arbiter.sv
// Round-robin front end that time-shares one external N-bit ripple-carry adder
// among NREQ requesters, running each W-bit addition one word per cycle, LSW first.
module rca_mw_arbiter #(
  parameter  int N     = 4,
  parameter  int WORDS = 2,
  parameter  int NREQ  = 2,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int W     = N * WORDS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  input  logic [NREQ-1:0]     req_cin,
  output logic [N-1:0]        rca_a,
  output logic [N-1:0]        rca_b,
  output logic                rca_cin,
  input  logic [N-1:0]        rca_s,
  input  logic                rca_cout,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W-1:0]        rsp_sum,
  output logic                rsp_cout,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy
);

  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [W-1:0]      a_r, b_r, acc_r, rsp_sum_r;
  logic              carry_r, rsp_cout_r, rsp_valid_r;
  logic [IDW-1:0]    id_r, rsp_id_r, last_r;
  logic [KW-1:0]     k_r;

  logic [NREQ-1:0]   grant_s;
  logic [IDW-1:0]    grant_id_s;
  logic              grant_any_s;
  logic [W-1:0]      sel_a_s, sel_b_s, acc_nxt_s;
  logic              sel_cin_s;
  logic              last_word_s;
  logic              hit_s;
  int                idx_s;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    grant_s     = {NREQ{1'b0}};
    grant_id_s  = {IDW{1'b0}};
    grant_any_s = 1'b0;
    hit_s       = 1'b0;
    idx_s       = 0;
    for (int j = 0; j < NREQ; j++) begin
      idx_s          = (int'(last_r) + 1 + j) % NREQ;
      hit_s          = req_valid[idx_s] & ~grant_any_s;
      grant_s[idx_s] = grant_s[idx_s] | hit_s;
      grant_id_s     = grant_id_s | (hit_s ? IDW'(idx_s) : {IDW{1'b0}});
      grant_any_s    = grant_any_s | hit_s;
    end
  end

  // One-hot AND-OR mux selecting the granted requester's operands.
  always_comb begin
    sel_a_s   = {W{1'b0}};
    sel_b_s   = {W{1'b0}};
    sel_cin_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a_s   = sel_a_s | ({W{grant_s[i]}} & req_a[i*W +: W]);
      sel_b_s   = sel_b_s | ({W{grant_s[i]}} & req_b[i*W +: W]);
      sel_cin_s = sel_cin_s | (grant_s[i] & req_cin[i]);
    end
  end

  // Accumulator with the current word's adder sum merged in.
  always_comb begin
    acc_nxt_s              = acc_r;
    acc_nxt_s[k_r*N +: N]  = rca_s;
    last_word_s            = (k_r == KW'(WORDS - 1));
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = grant_any_s ? RUN : IDLE;
      RUN:     state_nxt_s = last_word_s ? RESP : RUN;
      RESP:    state_nxt_s = rsp_ready ? IDLE : RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, operand capture, word-serial accumulation and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      acc_r       <= {W{1'b0}};
      rsp_sum_r   <= {W{1'b0}};
      carry_r     <= 1'b0;
      rsp_cout_r  <= 1'b0;
      rsp_valid_r <= 1'b0;
      id_r        <= {IDW{1'b0}};
      rsp_id_r    <= {IDW{1'b0}};
      last_r      <= IDW'(NREQ - 1);
      k_r         <= {KW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (grant_any_s) begin
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            carry_r <= sel_cin_s;
            id_r    <= grant_id_s;
            k_r     <= {KW{1'b0}};
          end
        end
        RUN: begin
          acc_r   <= acc_nxt_s;
          carry_r <= rca_cout;
          k_r     <= k_r + KW'(1);
          // The response registers change only here, so they hold through IDLE.
          if (last_word_s) begin
            rsp_sum_r   <= acc_nxt_s;
            rsp_cout_r  <= rca_cout;
            rsp_id_r    <= id_r;
            rsp_valid_r <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            last_r      <= id_r;
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Adder is driven only while a word is in flight; idle and response phases hold it at zero.
  always_comb begin
    rca_a   = {N{1'b0}};
    rca_b   = {N{1'b0}};
    rca_cin = 1'b0;
    if (state_r == RUN) begin
      rca_a   = a_r[k_r*N +: N];
      rca_b   = b_r[k_r*N +: N];
      rca_cin = carry_r;
    end else begin
      rca_cin = 1'b0;
    end
  end

  assign req_ready = (state_r == IDLE) ? grant_s : {NREQ{1'b0}};
  assign rsp_valid = rsp_valid_r;
  assign rsp_sum   = rsp_sum_r;
  assign rsp_cout  = rsp_cout_r;
  assign rsp_id    = rsp_id_r;
  assign busy      = (state_r == RUN) || (state_r == RESP);

endmodule

// File: doc/rca_mw_arbiter.md
Name: rca_mw_arbiter

Overview:
- Shares one external combinational N-bit ripple-carry adder between NREQ requesters.
- Each request is a WORDS-word (N*WORDS-bit) addition. The block runs it through the shared adder one word per cycle, LSW first, and chains the carry between words.
- Requesters are picked by round-robin; one result is returned at a time over a valid/ready response channel.
- Sits between client logic and the RCA instance, in place of direct wiring.

Parameters:
- N, 4, adder word width in bits.
- WORDS, 2, words per operand (operand width W = N*WORDS); WORDS >= 1.
- NREQ, 2, number of requesters; NREQ >= 1.
- IDW, max(1,$clog2(NREQ)), width of the requester id (derived, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request accept, one-hot or zero.
- req_a  in  NREQ*W  operand A; requester i at [i*W +: W].
- req_b  in  NREQ*W  operand B, same packing as req_a.
- req_cin  in  NREQ  carry-in per requester.
- rca_a  out  N  to adder, operand A word.
- rca_b  out  N  to adder, operand B word.
- rca_cin  out  1  to adder, carry-in.
- rca_s  in  N  from adder, sum word.
- rca_cout  in  1  from adder, carry-out.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accept.
- rsp_sum  out  W  full sum.
- rsp_cout  out  1  final carry-out.
- rsp_id  out  IDW  index of the requester served.
- busy  out  1  high in RUN and RESP.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0.
  - rca_a/rca_b/rca_cin=0; last-grant pointer=NREQ-1, so requester 0 has first priority.
  - Reset mid-operation aborts it silently: no response, and the captured operands are discarded.
- FSM IDLE:
  - req_ready is combinational and equals the one-hot grant g: the first i with req_valid[i]=1, searching from last_grant+1 with wrap-around. req_ready=0 if no request is valid.
  - On the edge where req_valid[g]&req_ready[g]:
    - capture A, B into internal registers;
    - carry<=req_cin[g], id<=g, word index k<=0;
    - go to RUN.
- FSM RUN:
  - rca_a=A[k*N +: N], rca_b=B[k*N +: N], rca_cin=carry (combinational from registers).
  - Each edge: sum[k*N +: N]<=rca_s, carry<=rca_cout, k<=k+1.
  - After the edge with k=WORDS-1, go to RESP.
  - req_ready=0 throughout.
- FSM RESP:
  - rsp_valid=1; rsp_sum, rsp_cout, rsp_id hold stable until rsp_ready=1.
  - On the edge where rsp_valid&rsp_ready: last_grant<=id, rsp_valid<=0, go to IDLE.
  - rsp_sum/rsp_cout/rsp_id retain their last values after the handshake.
- Adder inputs are forced to 0 in IDLE and RESP.
- Latency:
  - accept edge at t: RUN occupies cycles t..t+WORDS-1, and rsp_valid rises after edge t+WORDS.
  - Minimum issue interval is WORDS+2 cycles (RUN, RESP, IDLE).
- Arithmetic: {rsp_cout,rsp_sum} = A + B + cin, computed modulo 2^(W+1). There is no overflow flag.
- Requester protocol:
  - A requester may drop req_valid before acceptance; the block takes no action.
  - Operands are sampled only on the accept edge.
- Edge cases:
  - WORDS=1: a single RUN cycle.
  - NREQ=1: the arbiter degenerates to that requester; rsp_id=0.
- Fairness: a requester that keeps req_valid high is served within NREQ grants.

Test Plan:
(N=4, WORDS=2, NREQ=2, connected to a real RCA instance)
1. Single request: req0 a=0x3C, b=0x15, cin=0, rsp_ready=1 -> req_ready=01 for one cycle; rsp_sum=0x51, rsp_cout=0, rsp_id=0; rsp_valid rises 2 edges after accept.
2. Carry chaining:
   - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
   - a=0x0F, b=0x00, cin=1 -> sum=0x10, cout=0 (carry crosses the word boundary).
3. Round-robin: both req_valid held high with distinct operands -> grants 0,1,0,1; rsp_id alternates; no starvation.
4. Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=00, busy=1; on release, one handshake, then IDLE.
5. Reset mid-RUN: rst_n=0 at k=1 -> next cycle rsp_valid=0, busy=0, rca_*=0; with both requesting afterwards, the first grant goes to requester 0.
6. Random: 500 ops, random valids/operands/cin/rsp_ready -> every response equals the reference A+B+cin with the correct id; both values of rsp_cout and both ids are covered.
